// File: rtl/adc_iq_capture_if.sv
// rtl/adc_iq_capture_if.sv - downstream I/Q sample stream with sop/eop framing
interface adc_iq_capture_if;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_sop;
    logic        out_eop;

    modport master (output out_data, out_valid, out_sop, out_eop, input out_ready);
    modport slave  (input out_data, out_valid, out_sop, out_eop, output out_ready);
endinterface

// File: rtl/adc_iq_capture.sv
// rtl/adc_iq_capture.sv - dual-ADC I/Q capture front end with energy trigger and packet FIFO
// Optional ADC_DC_REMOVE_EN inserts a leaky-integrator DC removal stage between S1 and S2.
module adc_iq_capture #(
    parameter int FIFO_DEPTH = 16,
    parameter int LEN_W      = 16,
    parameter int HOLD_W     = 4,
    parameter int DC_SHIFT   = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [13:0]       adc_real,
    input  logic [13:0]       adc_imag,
    input  logic              adc_or_a,
    input  logic              adc_or_b,
    input  logic              adc_valid,
    input  logic              fmt_offset_bin,
    input  logic              arm,
    input  logic              force_trig,
    input  logic              abort,
    input  logic [LEN_W-1:0]  capture_len,
    input  logic [14:0]       trig_level,
    input  logic [HOLD_W-1:0] trig_hold,
    adc_iq_capture_if.master  dn,
    output logic              busy,
    output logic              done,
    output logic [15:0]       clip_cnt,
    output logic [15:0]       ovf_cnt
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    if (FIFO_DEPTH < 4 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || DC_SHIFT < 1) begin : g_bad_param
        $error("adc_iq_capture: FIFO_DEPTH must be a power of two >= 4 and DC_SHIFT >= 1");
    end

    typedef enum logic [1:0] {IDLE, ARMED, CAPTURE} state_t;

    logic [13:0] s1_i_q, s1_q_q;
    logic        s1_or_q, s1_full_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_i_q    <= '0;
            s1_q_q    <= '0;
            s1_or_q   <= 1'b0;
            s1_full_q <= 1'b0;
        end else if (adc_valid) begin
            s1_i_q    <= fmt_offset_bin ? {~adc_real[13], adc_real[12:0]} : adc_real;
            s1_q_q    <= fmt_offset_bin ? {~adc_imag[13], adc_imag[12:0]} : adc_imag;
            s1_or_q   <= adc_or_a | adc_or_b;
            s1_full_q <= 1'b1;
        end
    end

    logic [13:0] p_i, p_q;
    logic        p_or, p_full;

`ifdef ADC_DC_REMOVE_EN
    localparam int ACC_W = 14 + DC_SHIFT + 1;
    localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(8191);
    localparam logic signed [ACC_W-1:0] SAT_LO = -ACC_W'(8192);

    logic signed [ACC_W-1:0] acc_i_q, acc_q_q, dcv_i, dcv_q, dif_i, dif_q;
    logic [13:0]             dc_i_q, dc_q_q;
    logic                    dc_or_q, dc_full_q;

    function automatic logic [13:0] sat14(input logic signed [ACC_W-1:0] v);
        if (v > SAT_HI) return 14'h1FFF;
        if (v < SAT_LO) return 14'h2000;
        return v[13:0];
    endfunction

    always_comb begin
        dcv_i = acc_i_q >>> DC_SHIFT;
        dcv_q = acc_q_q >>> DC_SHIFT;
        dif_i = ACC_W'($signed(s1_i_q)) - dcv_i;
        dif_q = ACC_W'($signed(s1_q_q)) - dcv_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_i_q   <= '0;
            acc_q_q   <= '0;
            dc_i_q    <= '0;
            dc_q_q    <= '0;
            dc_or_q   <= 1'b0;
            dc_full_q <= 1'b0;
        end else if (adc_valid) begin
            dc_i_q    <= sat14(dif_i);
            dc_q_q    <= sat14(dif_q);
            dc_or_q   <= s1_or_q;
            dc_full_q <= s1_full_q;
            if (s1_full_q) begin
                acc_i_q <= acc_i_q + dif_i;
                acc_q_q <= acc_q_q + dif_q;
            end
        end
    end

    assign p_i    = dc_i_q;
    assign p_q    = dc_q_q;
    assign p_or   = dc_or_q;
    assign p_full = dc_full_q;
`else
    assign p_i    = s1_i_q;
    assign p_q    = s1_q_q;
    assign p_or   = s1_or_q;
    assign p_full = s1_full_q;
`endif

    // |-8192| = 8192 still fits in 15 bits, so two's complement negation is exact
    logic [14:0] abs_i, abs_q, mag;
    assign abs_i = p_i[13] ? (15'd0 - {p_i[13], p_i}) : {1'b0, p_i};
    assign abs_q = p_q[13] ? (15'd0 - {p_q[13], p_q}) : {1'b0, p_q};
    assign mag   = abs_i + abs_q;

    logic [13:0] s2_i_q, s2_q_q;
    logic        s2_or_q, s2_full_q, s2_qual_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            s2_i_q    <= '0;
            s2_q_q    <= '0;
            s2_or_q   <= 1'b0;
            s2_full_q <= 1'b0;
            s2_qual_q <= 1'b0;
        end else if (adc_valid) begin
            s2_i_q    <= p_i;
            s2_q_q    <= p_q;
            s2_or_q   <= p_or;
            s2_full_q <= p_full;
            s2_qual_q <= (mag >= trig_level);
        end
    end

    state_t            state_q;
    logic [LEN_W-1:0]  len_q, remain_q;
    logic [HOLD_W-1:0] hold_q;
    logic              done_q;
    logic [15:0]       clip_q, ovf_q;
    logic [CW-1:0]     fill, mcnt_q;
    logic              out_valid_q;

    logic              take, cap, cap_sop, cap_eop, admit;
    logic [HOLD_W:0]   hold_inc, hold_thr;

    // An S2 sample is consumed exactly once: on the valid strobe that replaces it
    assign take     = adc_valid && s2_full_q;
    assign hold_thr = (trig_hold == '0) ? (HOLD_W+1)'(1) : {1'b0, trig_hold};
    assign hold_inc = s2_qual_q ? ({1'b0, hold_q} + (HOLD_W+1)'(1)) : '0;
    assign fill     = mcnt_q + CW'(out_valid_q);

    always_comb begin
        cap     = 1'b0;
        cap_sop = 1'b0;
        cap_eop = 1'b0;
        if (take && !abort) begin
            if (state_q == ARMED && fill == '0 && (hold_inc >= hold_thr || force_trig)) begin
                cap     = 1'b1;
                cap_sop = 1'b1;
                cap_eop = (len_q == LEN_W'(1));
            end else if (state_q == CAPTURE) begin
                cap     = 1'b1;
                cap_eop = (remain_q == LEN_W'(1));
            end
        end
        // One slot stays reserved so the closing eop always fits
        admit = cap && (cap_eop ? (fill < CW'(FIFO_DEPTH)) : (fill < CW'(FIFO_DEPTH - 1)));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            len_q    <= '0;
            remain_q <= '0;
            hold_q   <= '0;
            done_q   <= 1'b0;
            clip_q   <= '0;
            ovf_q    <= '0;
        end else begin
            done_q <= cap && cap_eop;
            if (cap && s2_or_q && clip_q != 16'hFFFF) clip_q <= clip_q + 16'd1;
            if (cap && !admit && ovf_q != 16'hFFFF) ovf_q <= ovf_q + 16'd1;
            if (abort) begin
                state_q <= IDLE;
            end else begin
                case (state_q)
                    IDLE: if (arm) begin
                        state_q <= ARMED;
                        len_q   <= (capture_len == '0) ? LEN_W'(1) : capture_len;
                        hold_q  <= '0;
                        clip_q  <= '0;
                        ovf_q   <= '0;
                    end
                    ARMED: if (take && fill == '0) begin
                        hold_q <= hold_inc[HOLD_W-1:0];
                        if (cap) begin
                            hold_q <= '0;
                            if (cap_eop) state_q <= IDLE;
                            else begin
                                state_q  <= CAPTURE;
                                remain_q <= len_q - LEN_W'(1);
                            end
                        end
                    end
                    CAPTURE: if (cap) begin
                        if (cap_eop) state_q <= IDLE;
                        else remain_q <= remain_q - LEN_W'(1);
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    logic [33:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [33:0]   out_q, wr_word;
    logic          rd, load, pop, bypass, push;

    assign wr_word = {cap_sop, cap_eop, {2{s2_i_q[13]}}, s2_i_q, {2{s2_q_q[13]}}, s2_q_q};
    assign rd      = out_valid_q && dn.out_ready;
    assign load    = !out_valid_q || rd;
    assign pop     = load && mcnt_q != '0;
    assign bypass  = load && mcnt_q == '0 && admit;
    assign push    = admit && !bypass;

    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q] <= wr_word;
    end

    // The output register is the FIFO head; fill counts it as an occupied entry
    always_ff @(posedge clk) begin
        if (reset || abort) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            mcnt_q      <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            if (push) wptr_q <= wptr_q + AW'(1);
            if (pop) begin
                out_q  <= mem_q[rptr_q];
                rptr_q <= rptr_q + AW'(1);
            end else if (bypass) begin
                out_q <= wr_word;
            end
            if (load) out_valid_q <= pop || bypass;
            mcnt_q <= mcnt_q + CW'(push) - CW'(pop);
        end
    end

    assign dn.out_data  = out_q[31:0];
    assign dn.out_sop   = out_q[33];
    assign dn.out_eop   = out_q[32];
    assign dn.out_valid = out_valid_q;
    assign busy         = (state_q != IDLE);
    assign done         = done_q;
    assign clip_cnt     = clip_q;
    assign ovf_cnt      = ovf_q;
endmodule

// File: tb/tb_adc_iq_capture.sv
// tb/tb_adc_iq_capture.sv - randomized self-checking bench for adc_iq_capture
module tb_adc_iq_capture;
    localparam int DEPTH = 16;
`ifdef ADC_DC_REMOVE_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 3;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, adc_or_a, adc_or_b, adc_valid, fmt_offset_bin, arm, force_trig, abort;
    logic [13:0] adc_real, adc_imag;
    logic [15:0] capture_len, clip_cnt, ovf_cnt;
    logic [14:0] trig_level;
    logic [3:0]  trig_hold;
    logic        busy, done;

    adc_iq_capture_if dn();

    adc_iq_capture #(.FIFO_DEPTH(DEPTH), .LEN_W(16), .HOLD_W(4), .DC_SHIFT(10)) dut (
        .clk(clk), .reset(reset), .adc_real(adc_real), .adc_imag(adc_imag),
        .adc_or_a(adc_or_a), .adc_or_b(adc_or_b), .adc_valid(adc_valid),
        .fmt_offset_bin(fmt_offset_bin), .arm(arm), .force_trig(force_trig), .abort(abort),
        .capture_len(capture_len), .trig_level(trig_level), .trig_hold(trig_hold),
        .dn(dn), .busy(busy), .done(done), .clip_cnt(clip_cnt), .ovf_cnt(ovf_cnt)
    );

    int          n_vec = 0;
    int          n_bad = 0;
    int          rdy_mode = 2;
    int          done_seen = 0;
    logic [33:0] got_q[$];
    logic        prev_stall = 1'b0;
    logic [33:0] prev_word = '0;
    logic [13:0] sr[$], si[$];
    logic [1:0]  so[$];

    task automatic expect_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (prev_stall && dn.out_valid)
                expect_eq("hold_steady", {dn.out_sop, dn.out_eop, dn.out_data}, prev_word);
            if (dn.out_valid && dn.out_ready) got_q.push_back({dn.out_sop, dn.out_eop, dn.out_data});
            if (done) done_seen++;
            prev_stall = dn.out_valid && !dn.out_ready;
            prev_word  = {dn.out_sop, dn.out_eop, dn.out_data};
        end else begin
            prev_stall = 1'b0;
        end
    end

    function automatic int conv(input logic fmt, input logic [13:0] raw);
        if (fmt) return int'(raw) - 8192;
        return raw[13] ? int'(raw) - 16384 : int'(raw);
    endfunction

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    task automatic set_ready();
        case (rdy_mode)
            0:       dn.out_ready = ($urandom_range(0, 7) != 0);
            1:       dn.out_ready = 1'b0;
            default: dn.out_ready = 1'b1;
        endcase
    endtask

    task automatic present(input logic [13:0] r, input logic [13:0] q, input logic [1:0] orf);
        adc_real = r;
        adc_imag = q;
        {adc_or_b, adc_or_a} = orf;
        adc_valid = 1'b1;
        set_ready();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycle();
        adc_valid = 1'b0;
        set_ready();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        rdy_mode = 2;
        while ((dn.out_valid || busy) && n < 200) begin
            idle_cycle();
            n++;
        end
    endtask

    task automatic add(input logic [13:0] r, input logic [13:0] q, input logic [1:0] orf);
        sr.push_back(r);
        si.push_back(q);
        so.push_back(orf);
    endtask

    task automatic run_capture(input string tag, input logic fmt, input logic [14:0] lvl,
                               input logic [3:0] hld, input logic [15:0] len, input logic stall);
        logic [13:0] z;
        logic [13:0] lr[$], li[$];
        logic [1:0]  lo[$];
        logic [33:0] exp_q[$];
        logic        eop;
        int          L, thr, h, trig, fill, eclip, eovf, n;
        drain();
        fmt_offset_bin = fmt;
        trig_level     = lvl;
        trig_hold      = hld;
        capture_len    = len;
        z = fmt ? 14'h2000 : 14'h0000;
        repeat (3) present(z, z, 2'b00);
        arm = 1'b1;
        idle_cycle();
        arm = 1'b0;
        got_q.delete();
        done_seen = 0;

        L = (len == 0) ? 1 : int'(len);
        lr = sr;
        li = si;
        lo = so;
        for (int k = 0; k < L + 4; k++) begin
            lr.push_back(z);
            li.push_back(z);
            lo.push_back(2'b00);
        end

        thr  = (hld == 0) ? 1 : int'(hld);
        h    = 0;
        trig = -1;
        for (int k = 0; k < lr.size() && trig < 0; k++) begin
            if (iabs(conv(fmt, lr[k])) + iabs(conv(fmt, li[k])) >= int'(lvl)) h++;
            else h = 0;
            if (h >= thr) trig = k;
        end
        fill  = 0;
        eclip = 0;
        eovf  = 0;
        if (trig >= 0) begin
            for (int j = 0; j < L; j++) begin
                eop = (j == L - 1);
                if (lo[trig + j] != 2'b00) eclip++;
                if (!stall || fill < (eop ? DEPTH : DEPTH - 1)) begin
                    fill++;
                    exp_q.push_back({j == 0, eop, 16'(conv(fmt, lr[trig + j])), 16'(conv(fmt, li[trig + j]))});
                end else begin
                    eovf++;
                end
            end
        end

        rdy_mode = stall ? 1 : 0;
        for (int k = 0; k < lr.size(); k++) begin
            if (!stall && $urandom_range(0, 3) == 0) idle_cycle();
            present(lr[k], li[k], lo[k]);
        end
        if (stall) expect_eq({tag, "_ovf_stalled"}, ovf_cnt, eovf);

        if (trig >= 0) begin
            drain();
            expect_eq({tag, "_idle"}, {busy, dn.out_valid}, 2'b00);
        end else begin
            expect_eq({tag, "_still_armed"}, busy, 1'b1);
            rdy_mode = 2;
            abort = 1'b1;
            idle_cycle();
            abort = 1'b0;
            expect_eq({tag, "_abort_idle"}, busy, 1'b0);
        end

        expect_eq({tag, "_words"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int j = 0; j < n; j++) expect_eq({tag, "_word"}, got_q[j], exp_q[j]);
        expect_eq({tag, "_done"}, done_seen, (trig >= 0) ? 1 : 0);
        expect_eq({tag, "_clip"}, clip_cnt, eclip);
        expect_eq({tag, "_ovf"}, ovf_cnt, eovf);
        sr.delete();
        si.delete();
        so.delete();
    endtask

    initial begin
        int lat;
        reset = 1'b1;
        adc_real = '0; adc_imag = '0; adc_or_a = 1'b0; adc_or_b = 1'b0; adc_valid = 1'b0;
        fmt_offset_bin = 1'b0; arm = 1'b0; force_trig = 1'b0; abort = 1'b0;
        capture_len = '0; trig_level = '0; trig_hold = '0;
        dn.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        expect_eq("rst_busy", busy, 1'b0);
        expect_eq("rst_done", done, 1'b0);
        expect_eq("rst_stream", {dn.out_valid, dn.out_sop, dn.out_eop, dn.out_data}, 35'h0);
        expect_eq("rst_counters", {clip_cnt, ovf_cnt}, 32'h0);
        reset = 1'b0;

        // Latency and offset-binary conversion with force_trig
        fmt_offset_bin = 1'b1;
        trig_level = 15'd0;
        capture_len = 16'd4;
        force_trig = 1'b1;
        arm = 1'b1;
        idle_cycle();
        arm = 1'b0;
        got_q.delete();
        done_seen = 0;
        lat = -1;
        for (int k = 1; k <= 8; k++) begin
            present(14'h2000, 14'h3FFF, 2'b00);
            if (lat < 0 && dn.out_valid) lat = k;
        end
        force_trig = 1'b0;
        expect_eq("latency", lat, LAT);
        drain();
        expect_eq("lat_words", got_q.size(), 4);
        for (int j = 0; j < 4 && j < got_q.size(); j++)
            expect_eq("lat_word", got_q[j], {j == 0, j == 3, 32'h0000_1FFF});
        expect_eq("lat_done", done_seen, 1);

        // Trigger hold: only the sixth sample completes three qualifying in a row
        add(14'd1200, 14'd0, 2'b00);
        add(14'd0, 14'd1200, 2'b00);
        add(14'd250, 14'd250, 2'b00);
        add(14'h3B50, 14'd0, 2'b00);
        add(14'd0, 14'h3B50, 2'b00);
        add(14'd600, 14'd600, 2'b00);
        run_capture("hold", 1'b0, 15'd1000, 4'd3, 16'd3, 1'b0);
        expect_eq("hold_first", (got_q.size() > 0) ? got_q[0] : 34'h0, {2'b10, 32'h0258_0258});

        // Backpressure: nothing read while 40 samples are captured
        add(14'd5000, 14'd0, 2'b00);
        for (int k = 0; k < 45; k++) add(14'($urandom), 14'($urandom), 2'b00);
        run_capture("bp", 1'b0, 15'd1000, 4'd1, 16'd40, 1'b1);
        expect_eq("bp_ovf24", ovf_cnt, 16'd24);
        expect_eq("bp_last_eop", (got_q.size() > 0) ? got_q[got_q.size() - 1][32] : 1'b0, 1'b1);

        // len=0 and full-scale negative pair reaching mag 16384
        add(14'h1FFF, 14'h1FFF, 2'b00);
        add(14'h2000, 14'h2000, 2'b00);
        add(14'd3, 14'd3, 2'b00);
        run_capture("edge", 1'b0, 15'd16384, 4'd1, 16'd0, 1'b0);
        expect_eq("edge_word", (got_q.size() > 0) ? got_q[0] : 34'h0, {2'b11, 32'hE000_E000});

        // Clip: three captured samples flagged, one flagged sample after the packet
        add(14'd2000, 14'd0, 2'b00);
        add(14'd10, 14'd10, 2'b01);
        add(14'd20, 14'd20, 2'b00);
        add(14'd30, 14'd30, 2'b01);
        add(14'd40, 14'd40, 2'b00);
        add(14'd50, 14'd50, 2'b01);
        add(14'd60, 14'd60, 2'b01);
        run_capture("clip", 1'b0, 15'd1000, 4'd1, 16'd6, 1'b0);
        expect_eq("clip3", clip_cnt, 16'd3);

        for (int r = 0; r < 6; r++) begin
            for (int k = 0; k < 30; k++)
                add(14'($urandom), 14'($urandom), ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00);
            run_capture("rand", 1'($urandom), 15'($urandom_range(2000, 12000)), 4'($urandom_range(0, 3)),
                        16'($urandom_range(0, 12)), 1'b0);
        end

        // Abort mid-packet
        drain();
        fmt_offset_bin = 1'b0;
        capture_len = 16'd20;
        force_trig = 1'b1;
        arm = 1'b1;
        idle_cycle();
        arm = 1'b0;
        done_seen = 0;
        for (int k = 0; k < 7; k++) present(14'($urandom), 14'($urandom), 2'b00);
        expect_eq("abort_pre_busy", busy, 1'b1);
        abort = 1'b1;
        present(14'($urandom), 14'($urandom), 2'b00);
        abort = 1'b0;
        force_trig = 1'b0;
        expect_eq("abort_busy", busy, 1'b0);
        expect_eq("abort_valid", dn.out_valid, 1'b0);
        for (int k = 0; k < 25; k++) present(14'($urandom), 14'($urandom), 2'b00);
        expect_eq("abort_no_done", done_seen, 0);
        expect_eq("abort_stays_idle", {busy, dn.out_valid}, 2'b00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
